// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage datapath and pipe_hazard_ctrl.
// master = datapath side, slave = hazard controller side.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW   = 5,
  parameter int STALL_CW = 16
);
  // datapath -> controller
  logic              if_halt_insn;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_branch;
  logic              id_branch_taken;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;
  logic              mem_memread;
  logic              mem_memwrite;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrite;

  // controller -> datapath
  logic                pc_write;
  logic                if_id_write;
  logic                if_id_flush;
  logic                id_ex_bubble;
  logic                pipe_freeze;
  logic [1:0]          fwd_a;
  logic [1:0]          fwd_b;
  logic [1:0]          id_fwd_a;
  logic [1:0]          id_fwd_b;
  logic                halted;
  logic [STALL_CW-1:0] stall_count;

  modport master (
    output if_halt_insn, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_branch, id_branch_taken, ex_rs1, ex_rs2, ex_rd,
           ex_regwrite, ex_memread, mem_rd, mem_regwrite, mem_memread,
           mem_memwrite, wb_rd, wb_regwrite,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
           fwd_a, fwd_b, id_fwd_a, id_fwd_b, halted, stall_count
  );

  modport slave (
    input  if_halt_insn, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_branch, id_branch_taken, ex_rs1, ex_rs2, ex_rd,
           ex_regwrite, ex_memread, mem_rd, mem_regwrite, mem_memread,
           mem_memwrite, wb_rd, wb_regwrite,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
           fwd_a, fwd_b, id_fwd_a, id_fwd_b, halted, stall_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and pipeline-control block for the 5-stage RISC-V core.
// Covers load-use / branch-operand stalls, EX and ID forwarding, multi-cycle
// data-memory freeze, an interlock-only mode, a halt/drain sequence and a
// saturating stall counter.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_RUN     | normal issue; hazards, forwarding and flushes active
// ST_DRAIN   | halt word seen; fetch stopped, older insns drain out
// ST_HALTED  | pipeline empty; core parked until reset
module pipe_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int MEM_LAT    = 1,
  parameter int HALT_DRAIN = 4,
  parameter int FWD_EN     = 1,
  parameter int STALL_CW   = 16
) (
  input  logic              clock,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz_if
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
  localparam int DRN_W = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(HALT_DRAIN - 1);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    mcnt_q, mcnt_d;
  logic [DRN_W-1:0]    drain_q, drain_d;
  logic [STALL_CW-1:0] stall_cnt_q, stall_cnt_d;

  logic       ex_hit, mem_hit, wb_hit;
  logic       hz_raw, hz;
  logic       mem_op, freeze;
  logic       flush_run;
  logic [1:0] fwd_a_c, fwd_b_c, id_fwd_a_c, id_fwd_b_c;

  // x0 is hard-wired zero, so it never creates a dependency
  function automatic logic reg_match(input logic [REG_AW-1:0] a,
                                     input logic [REG_AW-1:0] b);
    return (a == b) && (a != '0);
  endfunction

  // Loads still in MEM have no data yet, so they are skipped as a source
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] m_rd,
                                         input logic              m_rw,
                                         input logic              m_mr,
                                         input logic [REG_AW-1:0] w_rd,
                                         input logic              w_rw);
    if (m_rw && !m_mr && reg_match(m_rd, rs)) return 2'b10;
    else if (w_rw && reg_match(w_rd, rs))     return 2'b01;
    else                                      return 2'b00;
  endfunction

  // RAW detection against each older stage, gated by which sources ID reads
  always_comb begin
    ex_hit  = (hz_if.id_use_rs1 && reg_match(hz_if.ex_rd,  hz_if.id_rs1)) ||
              (hz_if.id_use_rs2 && reg_match(hz_if.ex_rd,  hz_if.id_rs2));
    mem_hit = (hz_if.id_use_rs1 && reg_match(hz_if.mem_rd, hz_if.id_rs1)) ||
              (hz_if.id_use_rs2 && reg_match(hz_if.mem_rd, hz_if.id_rs2));
    wb_hit  = (hz_if.id_use_rs1 && reg_match(hz_if.wb_rd,  hz_if.id_rs1)) ||
              (hz_if.id_use_rs2 && reg_match(hz_if.wb_rd,  hz_if.id_rs2));
    if (FWD_EN != 0) begin
      // Only cases that forwarding cannot cover: load data not ready, or a
      // branch compare in ID needing a result still in EX or a load in MEM
      hz_raw = (hz_if.ex_memread && ex_hit) ||
               (hz_if.id_branch && hz_if.ex_regwrite && ex_hit) ||
               (hz_if.id_branch && hz_if.mem_memread && mem_hit);
    end else begin
      // Interlock mode: wait until the producer has fully left WB
      hz_raw = (hz_if.ex_regwrite  && ex_hit) ||
               (hz_if.mem_regwrite && mem_hit) ||
               (hz_if.wb_regwrite  && wb_hit);
    end
  end

  // Operand forwarding selects for EX and for the ID branch comparator
  always_comb begin
    fwd_a_c    = 2'b00;
    fwd_b_c    = 2'b00;
    id_fwd_a_c = 2'b00;
    id_fwd_b_c = 2'b00;
    if (FWD_EN != 0) begin
      fwd_a_c    = fwd_sel(hz_if.ex_rs1, hz_if.mem_rd, hz_if.mem_regwrite,
                           hz_if.mem_memread, hz_if.wb_rd, hz_if.wb_regwrite);
      fwd_b_c    = fwd_sel(hz_if.ex_rs2, hz_if.mem_rd, hz_if.mem_regwrite,
                           hz_if.mem_memread, hz_if.wb_rd, hz_if.wb_regwrite);
      id_fwd_a_c = fwd_sel(hz_if.id_rs1, hz_if.mem_rd, hz_if.mem_regwrite,
                           hz_if.mem_memread, hz_if.wb_rd, hz_if.wb_regwrite);
      id_fwd_b_c = fwd_sel(hz_if.id_rs2, hz_if.mem_rd, hz_if.mem_regwrite,
                           hz_if.mem_memread, hz_if.wb_rd, hz_if.wb_regwrite);
    end
  end

  // Memory-latency freeze: the op holds MEM until its last latency cycle
  always_comb begin
    mem_op    = hz_if.mem_memread || hz_if.mem_memwrite;
    freeze    = mem_op && (mcnt_q != CNT_LAST);
    mcnt_d    = freeze ? (mcnt_q + CNT_W'(1)) : '0;
    hz        = hz_raw && !freeze;
    flush_run = hz_if.id_branch_taken && !hz && !freeze;
  end

  // Halt/drain sequencing; the drain timer pauses while memory is frozen
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_RUN: begin
        // a halt word behind a taken branch is wrong-path and is ignored
        if (hz_if.if_halt_insn && !freeze && !hz && !flush_run) begin
          state_d = ST_DRAIN;
          drain_d = DRN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (!freeze) begin
          if (drain_q == '0) state_d = ST_HALTED;
          else               drain_d = drain_q - DRN_W'(1);
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Stall statistics count only while running and stick at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_RUN) && (freeze || hz) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + STALL_CW'(1);
  end

  // Pipeline control outputs; priority freeze > hazard > flush
  always_comb begin
    hz_if.pc_write     = 1'b1;
    hz_if.if_id_write  = 1'b1;
    hz_if.if_id_flush  = 1'b0;
    hz_if.id_ex_bubble = 1'b0;
    hz_if.pipe_freeze  = freeze;
    hz_if.fwd_a        = fwd_a_c;
    hz_if.fwd_b        = fwd_b_c;
    hz_if.id_fwd_a     = id_fwd_a_c;
    hz_if.id_fwd_b     = id_fwd_b_c;
    if (!reset) begin
      // hold the front end and inject bubbles for as long as reset is low
      hz_if.pc_write     = 1'b0;
      hz_if.if_id_write  = 1'b0;
      hz_if.id_ex_bubble = 1'b1;
      hz_if.pipe_freeze  = 1'b0;
      hz_if.fwd_a        = 2'b00;
      hz_if.fwd_b        = 2'b00;
      hz_if.id_fwd_a     = 2'b00;
      hz_if.id_fwd_b     = 2'b00;
    end else begin
      case (state_q)
        ST_RUN: begin
          hz_if.pc_write     = !freeze && !hz;
          hz_if.if_id_write  = !freeze && !hz;
          hz_if.id_ex_bubble = hz;
          hz_if.if_id_flush  = flush_run;
        end
        ST_DRAIN: begin
          hz_if.pc_write     = 1'b0;
          hz_if.if_id_write  = 1'b0;
          hz_if.id_ex_bubble = hz;
          hz_if.if_id_flush  = !freeze;
        end
        default: begin
          hz_if.pc_write     = 1'b0;
          hz_if.if_id_write  = 1'b0;
          hz_if.id_ex_bubble = 1'b1;
        end
      endcase
    end
  end

  assign hz_if.halted      = (state_q == ST_HALTED);
  assign hz_if.stall_count = stall_cnt_q;

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      mcnt_q      <= '0;
      drain_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mcnt_q      <= mcnt_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Three instances share one stimulus:
// d0 default (forwarding, MEM_LAT=1), d1 MEM_LAT=3, d2 interlock-only.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       halt;
    logic [4:0] id_rs1, id_rs2;
    logic       use1, use2, br, taken;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       ex_rw, ex_mr;
    logic [4:0] mem_rd;
    logic       mem_rw, mem_mr, mem_mw;
    logic [4:0] wb_rd;
    logic       wb_rw;
  } in_t;

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
  //  fwd_a, fwd_b, id_fwd_a, id_fwd_b}
  typedef struct packed {
    logic       pcw, ifw, fl, bub, frz;
    logic [1:0] fa, fb, ifa, ifb;
  } out_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  logic clock;
  logic reset;
  in_t  vin;
  out_t act [3];
  logic [15:0] cnt [3];
  logic        hl [3];

  int n_cmp = 0;
  int n_bad = 0;

  pipe_hazard_ctrl_if #(.REG_AW(5), .STALL_CW(16)) if0 ();
  pipe_hazard_ctrl_if #(.REG_AW(5), .STALL_CW(16)) if1 ();
  pipe_hazard_ctrl_if #(.REG_AW(5), .STALL_CW(16)) if2 ();

  pipe_hazard_ctrl #(.REG_AW(5), .MEM_LAT(1), .HALT_DRAIN(4), .FWD_EN(1), .STALL_CW(16))
    u_d0 (.clock(clock), .reset(reset), .hz_if(if0));
  pipe_hazard_ctrl #(.REG_AW(5), .MEM_LAT(3), .HALT_DRAIN(4), .FWD_EN(1), .STALL_CW(16))
    u_d1 (.clock(clock), .reset(reset), .hz_if(if1));
  pipe_hazard_ctrl #(.REG_AW(5), .MEM_LAT(1), .HALT_DRAIN(4), .FWD_EN(0), .STALL_CW(16))
    u_d2 (.clock(clock), .reset(reset), .hz_if(if2));

`define DRV_IF(IFN, IDX) \
  assign IFN.if_halt_insn    = vin.halt; \
  assign IFN.id_rs1          = vin.id_rs1; \
  assign IFN.id_rs2          = vin.id_rs2; \
  assign IFN.id_use_rs1      = vin.use1; \
  assign IFN.id_use_rs2      = vin.use2; \
  assign IFN.id_branch       = vin.br; \
  assign IFN.id_branch_taken = vin.taken; \
  assign IFN.ex_rs1          = vin.ex_rs1; \
  assign IFN.ex_rs2          = vin.ex_rs2; \
  assign IFN.ex_rd           = vin.ex_rd; \
  assign IFN.ex_regwrite     = vin.ex_rw; \
  assign IFN.ex_memread      = vin.ex_mr; \
  assign IFN.mem_rd          = vin.mem_rd; \
  assign IFN.mem_regwrite    = vin.mem_rw; \
  assign IFN.mem_memread     = vin.mem_mr; \
  assign IFN.mem_memwrite    = vin.mem_mw; \
  assign IFN.wb_rd           = vin.wb_rd; \
  assign IFN.wb_regwrite     = vin.wb_rw; \
  assign act[IDX] = {IFN.pc_write, IFN.if_id_write, IFN.if_id_flush, IFN.id_ex_bubble, \
                     IFN.pipe_freeze, IFN.fwd_a, IFN.fwd_b, IFN.id_fwd_a, IFN.id_fwd_b}; \
  assign cnt[IDX] = IFN.stall_count; \
  assign hl[IDX]  = IFN.halted;

  `DRV_IF(if0, 0)
  `DRV_IF(if1, 1)
  `DRV_IF(if2, 2)

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic out_t mk(input logic pcw, input logic ifw, input logic fl,
                              input logic bub, input logic frz,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic [1:0] ifa, input logic [1:0] ifb);
    out_t o;
    o.pcw = pcw; o.ifw = ifw; o.fl = fl; o.bub = bub; o.frz = frz;
    o.fa = fa; o.fb = fb; o.ifa = ifa; o.ifb = ifb;
    return o;
  endfunction

  task automatic chk_o(input string nm, input out_t a, input out_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, a, e);
    end
  endtask

  task automatic chk_v(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  // apply one vector just after a falling edge, check, wait for the next one
  task automatic cyc(input string nm, input int d, input in_t v, input out_t e);
    vin = v;
    #1;
    chk_o(nm, act[d], e);
    @(negedge clock);
  endtask

  task automatic do_reset();
    vin   = '0;
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    vec_t tbl[$];
    in_t  v;
    out_t o_norm, o_hz, o_rst, o_drain;

    o_norm  = mk(1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    o_hz    = mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    o_rst   = mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    o_drain = mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);

    // ---------------- reset: outputs forced while reset is low
    reset = 1'b0;
    v = '0; v.halt = 1; v.taken = 1; v.ex_mr = 1; v.ex_rw = 1; v.ex_rd = 5;
    v.id_rs1 = 5; v.use1 = 1; v.mem_rw = 1; v.mem_mw = 1; v.mem_rd = 3; v.ex_rs1 = 3;
    vin = v;
    #3;
    for (int d = 0; d < 3; d++) begin
      chk_o($sformatf("reset_out_d%0d", d), act[d], o_rst);
      chk_v($sformatf("reset_cnt_d%0d", d), 32'(cnt[d]), 0);
      chk_v($sformatf("reset_halted_d%0d", d), 32'(hl[d]), 0);
    end
    @(negedge clock);
    #1;
    chk_o("reset_held_d1", act[1], o_rst);
    chk_v("reset_held_cnt_d1", 32'(cnt[1]), 0);
    do_reset();

    // ---------------- test 1: single load-use bubble
    v = '0; v.ex_mr = 1; v.ex_rw = 1; v.ex_rd = 5; v.id_rs1 = 5; v.use1 = 1;
    cyc("ld_use_one", 0, v, o_hz);
    vin = '0;
    #1;
    chk_o("ld_use_after", act[0], o_norm);
    chk_v("ld_use_cnt", 32'(cnt[0]), 1);
    do_reset();

    // ---------------- table of single-cycle vectors on d0
    v = '0;
    tbl.push_back('{"idle", v, o_norm});
    v = '0; v.ex_mr = 1; v.ex_rw = 1; v.ex_rd = 5; v.id_rs1 = 5; v.use1 = 1;
    tbl.push_back('{"lduse_rs1", v, o_hz});
    v.use1 = 0;
    tbl.push_back('{"lduse_unused", v, o_norm});
    v = '0; v.ex_mr = 1; v.ex_rw = 1; v.ex_rd = 7; v.id_rs2 = 7; v.use2 = 1;
    tbl.push_back('{"lduse_rs2", v, o_hz});
    v = '0; v.ex_mr = 1; v.ex_rw = 1; v.ex_rd = 0; v.id_rs1 = 0; v.use1 = 1;
    tbl.push_back('{"lduse_x0", v, o_norm});
    v = '0; v.mem_rw = 1; v.mem_rd = 3; v.wb_rw = 1; v.wb_rd = 3; v.ex_rs1 = 3;
    tbl.push_back('{"fwd_a_mem", v, mk(1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00)});
    v.mem_rw = 0;
    tbl.push_back('{"fwd_a_wb", v, mk(1, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00)});
    v = '0; v.mem_rw = 1; v.wb_rw = 1;
    tbl.push_back('{"fwd_x0", v, o_norm});
    v = '0; v.mem_rw = 1; v.mem_mr = 1; v.mem_rd = 4; v.wb_rw = 1; v.wb_rd = 4; v.ex_rs2 = 4;
    tbl.push_back('{"fwd_b_skip_load", v, mk(1, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00)});
    v = '0; v.mem_rw = 1; v.mem_rd = 6; v.ex_rs2 = 6; v.wb_rw = 1; v.wb_rd = 2; v.ex_rs1 = 2;
    tbl.push_back('{"fwd_ab_mix", v, mk(1, 1, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00)});
    v = '0; v.br = 1; v.taken = 1; v.id_rs1 = 8; v.use1 = 1; v.ex_rw = 1; v.ex_rd = 8;
    tbl.push_back('{"br_ex_hz", v, o_hz});
    v = '0; v.br = 1; v.id_rs2 = 9; v.use2 = 1; v.mem_rw = 1; v.mem_mr = 1; v.mem_rd = 9;
    tbl.push_back('{"br_memload_hz", v, o_hz});
    v = '0; v.br = 1; v.taken = 1; v.id_rs1 = 9; v.use1 = 1; v.mem_rw = 1; v.mem_rd = 9;
    tbl.push_back('{"br_fwd_mem_flush", v, mk(1, 1, 1, 0, 0, 2'b00, 2'b00, 2'b10, 2'b00)});
    v = '0; v.br = 1; v.id_rs2 = 10; v.use2 = 1; v.wb_rw = 1; v.wb_rd = 10;
    tbl.push_back('{"br_fwd_wb", v, mk(1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01)});
    v = '0; v.ex_rw = 1; v.ex_rd = 8; v.id_rs1 = 8; v.use1 = 1;
    tbl.push_back('{"alu_dep_no_hz", v, o_norm});

    foreach (tbl[i]) cyc(tbl[i].name, 0, tbl[i].in, tbl[i].exp);
    vin = '0;
    #1;
    chk_v("table_stall_cnt", 32'(cnt[0]), 4);

    // ---------------- test 3: MEM_LAT=3 freeze masks a load-use hazard
    do_reset();
    v = '0; v.mem_mw = 1; v.ex_mr = 1; v.ex_rw = 1; v.ex_rd = 5; v.id_rs1 = 5; v.use1 = 1;
    cyc("frz_c1", 1, v, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00));
    cyc("frz_c2", 1, v, mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00));
    cyc("frz_c3_hz", 1, v, o_hz);
    v = '0; v.mem_mr = 1;
    vin = v;
    #1;
    chk_o("frz_restart", act[1], mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00));
    chk_v("frz_stall_cnt", 32'(cnt[1]), 3);
    @(negedge clock);

    // ---------------- test 4: branch hazard then forwarded compare + flush
    do_reset();
    v = '0; v.br = 1; v.taken = 1; v.id_rs1 = 8; v.use1 = 1; v.ex_rw = 1; v.ex_rd = 8;
    cyc("beq_hz", 0, v, o_hz);
    v = '0; v.br = 1; v.taken = 1; v.id_rs1 = 8; v.use1 = 1; v.mem_rw = 1; v.mem_rd = 8;
    cyc("beq_fwd_flush", 0, v, mk(1, 1, 1, 0, 0, 2'b00, 2'b00, 2'b10, 2'b00));
    cyc("beq_after", 0, '0, o_norm);

    // ---------------- test 5: halt, drain, halted, absorbing
    do_reset();
    v = '0; v.halt = 1;
    cyc("halt_fetch", 0, v, o_norm);
    for (int k = 0; k < 4; k++) begin
      vin = '0;
      #1;
      chk_o($sformatf("drain_%0d", k), act[0], o_drain);
      chk_v($sformatf("drain_halted_%0d", k), 32'(hl[0]), 0);
      @(negedge clock);
    end
    for (int k = 0; k < 3; k++) begin
      v = '0; v.taken = (k == 1); v.halt = (k == 2);
      vin = v;
      #1;
      chk_o($sformatf("halted_out_%0d", k), act[0], o_rst);
      chk_v($sformatf("halted_flag_%0d", k), 32'(hl[0]), 1);
      @(negedge clock);
    end
    chk_v("halted_cnt_frozen", 32'(cnt[0]), 0);
    reset = 1'b0;
    #1;
    chk_v("halted_async_clear", 32'(hl[0]), 0);
    chk_o("halted_reset_out", act[0], o_rst);
    @(negedge clock);
    reset = 1'b1;

    // reset in the middle of DRAIN returns to RUN
    v = '0; v.halt = 1;
    cyc("halt2_fetch", 0, v, o_norm);
    cyc("halt2_drain0", 0, '0, o_drain);
    reset = 1'b0;
    #1;
    chk_o("mid_drain_reset", act[0], o_rst);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) cyc($sformatf("post_drain_rst_%0d", k), 0, '0, o_norm);
    chk_v("post_drain_rst_halted", 32'(hl[0]), 0);

    // halt word alongside a taken branch is wrong-path
    do_reset();
    v = '0; v.halt = 1; v.br = 1; v.taken = 1;
    cyc("halt_wrongpath", 0, v, mk(1, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    for (int k = 0; k < 6; k++) cyc($sformatf("wrongpath_run_%0d", k), 0, '0, o_norm);
    chk_v("wrongpath_halted", 32'(hl[0]), 0);

    // ---------------- test 6: interlock-only mode
    do_reset();
    v = '0; v.id_rs1 = 1; v.use1 = 1; v.ex_rw = 1; v.ex_rd = 1;
    cyc("nofwd_ex", 2, v, o_hz);
    v = '0; v.id_rs1 = 1; v.use1 = 1; v.mem_rw = 1; v.mem_rd = 1; v.ex_rs1 = 1; v.ex_rs2 = 1;
    cyc("nofwd_mem", 2, v, o_hz);
    v = '0; v.id_rs1 = 1; v.use1 = 1; v.wb_rw = 1; v.wb_rd = 1; v.ex_rs1 = 1; v.br = 1;
    cyc("nofwd_wb", 2, v, o_hz);
    v = '0; v.id_rs1 = 1; v.use1 = 1;
    vin = v;
    #1;
    chk_o("nofwd_release", act[2], o_norm);
    chk_v("nofwd_stall_cnt", 32'(cnt[2]), 3);
    @(negedge clock);
    v = '0; v.id_rs1 = 0; v.use1 = 1; v.ex_rw = 1; v.ex_rd = 0;
    cyc("nofwd_x0", 2, v, o_norm);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
